// File: rtl/led_scan_display_controller_if.sv
// Frame/brightness bus between display-formatting logic and the LED scanner.
interface led_scan_display_controller_if #(
    parameter int NUM_DIGITS   = 4,
    parameter int BRIGHT_WIDTH = 3
);
    logic [NUM_DIGITS*8-1:0] i_frame;
    logic                    i_frame_stb;
    logic                    o_frame_ack;
    logic [BRIGHT_WIDTH-1:0] i_brightness;

    modport master (
        output i_frame,
        output i_frame_stb,
        output i_brightness,
        input  o_frame_ack
    );

    modport slave (
        input  i_frame,
        input  i_frame_stb,
        input  i_brightness,
        output o_frame_ack
    );
endinterface

// File: rtl/led_scan_display_controller.sv
// Multiplexed 7-segment scanner: double-buffered frame, anti-ghost clear,
// serial load of digit select (chain A) and segments (chain B), PWM brightness.
module led_scan_display_controller #(
    parameter int NUM_DIGITS        = 4,
    parameter int SEL_BITS          = 8,
    parameter int REFRESH_DIV       = 62000,
    parameter int REFRESH_DIV_WIDTH = 16,
    parameter int SHIFT_DIV         = 2,
    parameter int BRIGHT_WIDTH      = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    led_scan_display_controller_if.slave  bus,
    output logic [2:0]                    o_scan_digit,
    output logic                          o_shifter_a_ds,
    output logic                          o_shifter_a_cp,
    output logic                          o_shifter_a_mr_n,
    output logic                          o_shifter_b_ds,
    output logic                          o_shifter_b_cp,
    output logic                          o_shifter_b_mr_n
);
    localparam int NUM_BITS = (SEL_BITS > 8) ? SEL_BITS : 8;
    localparam int FRAME_W  = NUM_DIGITS * 8;
    localparam int DIV_W    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam int BIT_W    = $clog2(NUM_BITS);

    localparam logic [REFRESH_DIV_WIDTH-1:0] SLOT_LAST   = REFRESH_DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [BRIGHT_WIDTH-1:0]      BRIGHT_FULL = {BRIGHT_WIDTH{1'b1}};
    localparam logic [DIV_W-1:0]             DIV_LAST    = DIV_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0]             BIT_LAST    = BIT_W'(NUM_BITS - 1);
    localparam logic [2:0]                   DIGIT_LAST  = 3'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SHOW  = 3'd3,
        ST_BLANK = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [REFRESH_DIV_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]               digit_q, digit_d;
    logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
    logic                     phase_q, phase_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [FRAME_W-1:0]       pending_q, pending_d;
    logic                     pending_valid_q, pending_valid_d;
    logic [FRAME_W-1:0]       active_q, active_d;
    logic                     ack_q, ack_d;
    logic                     a_ds_q, a_ds_d, a_cp_q, a_cp_d, a_mr_n_q, a_mr_n_d;
    logic                     b_ds_q, b_ds_d, b_cp_q, b_cp_d, b_mr_n_q, b_mr_n_d;

    logic                         slot_start_s;
    logic                         advance_s;
    logic [2:0]                   next_digit_s;
    logic                         full_s;
    logic                         dark_s;
    logic [REFRESH_DIV_WIDTH-1:0] threshold_s;
    logic                         shift_done_s;
    logic [7:0]                   seg_byte_s;
    logic [31:0]                  bit_ext_s;
    logic [31:0]                  sel_pos_s;

    assign slot_start_s = (slot_cnt_q == '0) && !i_reset;
    assign advance_s    = slot_start_s && ((state_q == ST_IDLE) || (state_q == ST_SHOW) || (state_q == ST_BLANK));
    assign next_digit_s = ((state_q == ST_IDLE) || (digit_q == DIGIT_LAST)) ? 3'd0 : (digit_q + 3'd1);
    assign full_s       = (bus.i_brightness == BRIGHT_FULL);
    assign dark_s       = (bus.i_brightness == '0);
    assign threshold_s  = REFRESH_DIV_WIDTH'(bus.i_brightness) << (REFRESH_DIV_WIDTH - BRIGHT_WIDTH);
    assign shift_done_s = phase_q && (div_cnt_q == DIV_LAST) && (bit_q == BIT_LAST);

    // State, counters, buffers and registered pins; synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q         <= ST_IDLE;
            slot_cnt_q      <= '0;
            digit_q         <= 3'd0;
            div_cnt_q       <= '0;
            phase_q         <= 1'b0;
            bit_q           <= '0;
            pending_q       <= {FRAME_W{1'b1}};
            pending_valid_q <= 1'b0;
            active_q        <= {FRAME_W{1'b1}};
            ack_q           <= 1'b0;
            a_ds_q          <= 1'b0;
            a_cp_q          <= 1'b0;
            a_mr_n_q        <= 1'b0;
            b_ds_q          <= 1'b0;
            b_cp_q          <= 1'b0;
            b_mr_n_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_cnt_q      <= slot_cnt_d;
            digit_q         <= digit_d;
            div_cnt_q       <= div_cnt_d;
            phase_q         <= phase_d;
            bit_q           <= bit_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            ack_q           <= ack_d;
            a_ds_q          <= a_ds_d;
            a_cp_q          <= a_cp_d;
            a_mr_n_q        <= a_mr_n_d;
            b_ds_q          <= b_ds_d;
            b_cp_q          <= b_cp_d;
            b_mr_n_q        <= b_mr_n_d;
        end
    end

    // Next-state logic of the scan FSM; a slot start always wins in SHOW
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (slot_start_s) state_d = ST_CLEAR;
                else              state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (dark_s) state_d = ST_BLANK;
                else        state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_done_s) state_d = ST_SHOW;
                else              state_d = ST_SHIFT;
            end
            ST_SHOW: begin
                if (slot_start_s)                               state_d = ST_CLEAR;
                else if (!full_s && (slot_cnt_q >= threshold_s)) state_d = ST_BLANK;
                else                                            state_d = ST_SHOW;
            end
            ST_BLANK: begin
                if (slot_start_s) state_d = ST_CLEAR;
                else              state_d = ST_BLANK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot timer, digit index and bit-time counters
    always_comb begin
        slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : (slot_cnt_q + REFRESH_DIV_WIDTH'(1));
        if (advance_s) digit_d = next_digit_s;
        else           digit_d = digit_q;
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        if (state_q != ST_SHIFT) begin
            div_cnt_d = '0;
            phase_d   = 1'b0;
            bit_d     = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (phase_q) begin
                phase_d = 1'b0;
                bit_d   = bit_q + BIT_W'(1);
            end else begin
                phase_d = 1'b1;
                bit_d   = bit_q;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // Frame double buffer: promote at digit-0 slot start, a same-cycle strobe refills pending
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        ack_d           = 1'b0;
        if (advance_s && (next_digit_s == 3'd0) && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
            ack_d           = 1'b1;
        end else begin
            ack_d = 1'b0;
        end
        if (bus.i_frame_stb) begin
            pending_d       = bus.i_frame;
            pending_valid_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // Pin values for the coming cycle, derived from the next state so pins track the FSM
    always_comb begin
        seg_byte_s = active_d[{digit_d, 3'b000} +: 8];
        bit_ext_s  = 32'(bit_d);
        sel_pos_s  = 32'(NUM_DIGITS - 1) - 32'(digit_d);
        a_ds_d     = 1'b0;
        a_cp_d     = 1'b0;
        a_mr_n_d   = 1'b0;
        b_ds_d     = 1'b0;
        b_cp_d     = 1'b0;
        b_mr_n_d   = 1'b1;
        case (state_d)
            ST_SHIFT: begin
                a_mr_n_d = 1'b1;
                a_ds_d   = (bit_ext_s == sel_pos_s);
                a_cp_d   = phase_d;
                // chain B only needs 8 clocks; it idles while a longer chain A finishes
                if (bit_ext_s < 32'd8) begin
                    b_ds_d = seg_byte_s[3'd7 - bit_d[2:0]];
                    b_cp_d = phase_d;
                end else begin
                    b_ds_d = 1'b0;
                    b_cp_d = 1'b0;
                end
            end
            ST_SHOW: begin
                // digits go dark from the slot count that reaches the threshold
                if (full_s || (slot_cnt_d < threshold_s)) a_mr_n_d = 1'b1;
                else                                      a_mr_n_d = 1'b0;
            end
            ST_IDLE, ST_CLEAR, ST_BLANK: a_mr_n_d = 1'b0;
            default:                     a_mr_n_d = 1'b0;
        endcase
    end

    assign bus.o_frame_ack  = ack_q;
    assign o_scan_digit     = digit_q;
    assign o_shifter_a_ds   = a_ds_q;
    assign o_shifter_a_cp   = a_cp_q;
    assign o_shifter_a_mr_n = a_mr_n_q;
    assign o_shifter_b_ds   = b_ds_q;
    assign o_shifter_b_cp   = b_cp_q;
    assign o_shifter_b_mr_n = b_mr_n_q;
endmodule

// File: tb/tb_led_scan_display_controller.sv
// Self-checking bench: per-slot vector table, shift-register pin monitor and
// an expected-shift scoreboard queue.
module tb_led_scan_display_controller;
    logic       clk = 1'b0;
    logic       i_reset;
    logic [2:0] o_scan_digit;
    logic       a_ds, a_cp, a_mr_n, b_ds, b_cp, b_mr_n;

    led_scan_display_controller_if #(.NUM_DIGITS(4), .BRIGHT_WIDTH(2)) bus ();

    led_scan_display_controller #(
        .NUM_DIGITS(4), .SEL_BITS(8), .REFRESH_DIV(64), .REFRESH_DIV_WIDTH(6),
        .SHIFT_DIV(1), .BRIGHT_WIDTH(2)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .bus(bus), .o_scan_digit(o_scan_digit),
        .o_shifter_a_ds(a_ds), .o_shifter_a_cp(a_cp), .o_shifter_a_mr_n(a_mr_n),
        .o_shifter_b_ds(b_ds), .o_shifter_b_cp(b_cp), .o_shifter_b_mr_n(b_mr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bright;
        int          stb_at;
        logic [31:0] frame;
        logic [2:0]  digit;
        logic [7:0]  sel;
        logic [7:0]  seg;
        int          acks;
    } vec_t;

    typedef struct {
        logic [2:0] digit;
        logic [7:0] sel;
        logic [7:0] seg;
    } exp_t;

    vec_t vecs[23];
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int edges_a = 0, edges_b = 0, last_a = 0, last_b = 0;
    int slot_edges_a = 0, slot_edges_b = 0, slot_acks = 0;
    logic [7:0] sr_a = 8'h00, sr_b = 8'h00;
    logic prev_a = 1'b0, prev_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] br, input int stb, input logic [31:0] fr,
                                input logic [2:0] dg, input logic [7:0] sl, input logic [7:0] sg,
                                input int ak);
        vec_t v;
        v.bright = br; v.stb_at = stb; v.frame = fr; v.digit = dg;
        v.sel = sl; v.seg = sg; v.acks = ak;
        return v;
    endfunction

    // One clock: sample #1 after the edge and model both external shift chains
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (bus.o_frame_ack) slot_acks++;
        if (a_cp && !prev_a) slot_edges_a++;
        if (b_cp && !prev_b) slot_edges_b++;
        if (!a_mr_n) begin
            edges_a = 0; edges_b = 0; sr_a = 8'h00; sr_b = 8'h00;
        end else begin
            if (b_cp && !prev_b) begin
                sr_b = {sr_b[6:0], b_ds};
                edges_b++;
                if (edges_b > 1) check("cp_b_spacing", cycle - last_b, 2);
                last_b = cycle;
            end
            if (a_cp && !prev_a) begin
                sr_a = {sr_a[6:0], a_ds};
                edges_a++;
                if (edges_a > 1) check("cp_a_spacing", cycle - last_a, 2);
                last_a = cycle;
            end
            if (edges_a == 8) begin
                check("shift_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("chain_a_sel", sr_a, e.sel);
                    check("chain_b_seg", sr_b, e.seg);
                    check("chain_b_edges", edges_b, 8);
                    check("digit_at_shift", o_scan_digit, e.digit);
                end
                edges_a = 0; edges_b = 0;
            end
        end
        prev_a = a_cp;
        prev_b = b_cp;
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            check("reset_pins", {a_ds, a_cp, a_mr_n, b_ds, b_cp, b_mr_n, bus.o_frame_ack}, 7'b0);
            check("reset_digit", o_scan_digit, 0);
        end
        i_reset = 1'b0;
    endtask

    // One full 64-cycle slot starting at the next slot_start edge
    task automatic run_slot(input vec_t v);
        exp_t e;
        int thr;
        logic exp_mr;
        bus.i_brightness = v.bright;
        thr = int'(v.bright) * 16;
        if (v.bright != 2'd0) begin
            e.digit = v.digit; e.sel = v.sel; e.seg = v.seg;
            sb_q.push_back(e);
        end
        slot_acks = 0; slot_edges_a = 0; slot_edges_b = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 1)                exp_mr = 1'b0;
            else if (v.bright == 2'd0) exp_mr = 1'b0;
            else if (i <= 17)          exp_mr = 1'b1;
            else if (v.bright == 2'd3) exp_mr = 1'b1;
            else                       exp_mr = (i < thr);
            check("mr_n_a", a_mr_n, exp_mr);
            check("mr_n_b", b_mr_n, 1);
            check("scan_digit", o_scan_digit, v.digit);
            bus.i_frame_stb = 1'b0;
            if (i == v.stb_at) begin
                bus.i_frame     = v.frame;
                bus.i_frame_stb = 1'b1;
            end
        end
        check("ack_count", slot_acks, v.acks);
        check("cp_a_edges", slot_edges_a, (v.bright == 2'd0) ? 0 : 8);
        check("cp_b_edges", slot_edges_b, (v.bright == 2'd0) ? 0 : 8);
        check("shift_seen", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        i_reset          = 1'b1;
        bus.i_frame      = 32'h0;
        bus.i_frame_stb  = 1'b0;
        bus.i_brightness = 2'd3;

        vecs[0]  = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'hFF, 0);
        vecs[1]  = mk(2'd3,  0, 32'h0,        3'd1, 8'h20, 8'hFF, 0);
        vecs[2]  = mk(2'd3, 20, 32'h039F250D, 3'd2, 8'h40, 8'hFF, 0);
        vecs[3]  = mk(2'd3,  0, 32'h0,        3'd3, 8'h80, 8'hFF, 0);
        vecs[4]  = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'h0D, 1);
        vecs[5]  = mk(2'd2,  0, 32'h0,        3'd1, 8'h20, 8'h25, 0);
        vecs[6]  = mk(2'd1,  0, 32'h0,        3'd2, 8'h40, 8'h9F, 0);
        vecs[7]  = mk(2'd0,  0, 32'h0,        3'd3, 8'h80, 8'h03, 0);
        vecs[8]  = mk(2'd3, 10, 32'h11223344, 3'd0, 8'h10, 8'h0D, 0);
        vecs[9]  = mk(2'd3, 30, 32'h55667788, 3'd1, 8'h20, 8'h25, 0);
        vecs[10] = mk(2'd3,  0, 32'h0,        3'd2, 8'h40, 8'h9F, 0);
        vecs[11] = mk(2'd3, 64, 32'hAABBCCDD, 3'd3, 8'h80, 8'h03, 0);
        vecs[12] = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'h88, 1);
        vecs[13] = mk(2'd3,  0, 32'h0,        3'd1, 8'h20, 8'h77, 0);
        vecs[14] = mk(2'd3,  0, 32'h0,        3'd2, 8'h40, 8'h66, 0);
        vecs[15] = mk(2'd3,  0, 32'h0,        3'd3, 8'h80, 8'h55, 0);
        vecs[16] = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'hDD, 1);
        vecs[17] = mk(2'd3,  0, 32'h0,        3'd1, 8'h20, 8'hCC, 0);
        vecs[18] = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'hFF, 0);
        vecs[19] = mk(2'd3,  0, 32'h0,        3'd1, 8'h20, 8'hFF, 0);
        vecs[20] = mk(2'd3,  0, 32'h0,        3'd2, 8'h40, 8'hFF, 0);
        vecs[21] = mk(2'd3,  0, 32'h0,        3'd3, 8'h80, 8'hFF, 0);
        vecs[22] = mk(2'd3,  0, 32'h0,        3'd0, 8'h10, 8'hFF, 0);

        do_reset(3);

        for (int k = 0; k < 23; k++) begin
            if (k == 18) begin
                // partial digit-2 slot: queue a frame, then reset in the middle of SHIFT
                bus.i_brightness = 2'd3;
                for (int i = 1; i <= 8; i++) begin
                    tick();
                    bus.i_frame_stb = 1'b0;
                    if (i == 3) begin
                        bus.i_frame     = 32'h00000000;
                        bus.i_frame_stb = 1'b1;
                    end
                end
                check("mid_shift_digit", o_scan_digit, 2);
                check("mid_shift_mr_n_a", a_mr_n, 1);
                do_reset(2);
            end
            run_slot(vecs[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
